mem_arbiter: RTL

Two-port to one-port memory arbiter for the 5-stage MIPS core. It lets the instruction-fetch port and the data (MEM-stage) port share a single backing memory with variable latency, of the same ren/wen/ack style as the existing ROM/RAM models. Data accesses have priority, and a bounded starvation counter guarantees forward progress for fetch. Completed accesses are held, not re-issued, while the core is stalled for other reasons.

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and backing-memory signals of the two-to-one memory arbiter.
// Rev 1.0
`default_nettype none

interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  i_ren;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [31:0]           i_dout;
  logic                  i_stall;

  logic                  d_ren;
  logic                  d_wen;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [31:0]           d_din;
  logic [31:0]           d_dout;
  logic                  d_stall;

  logic                  m_ren;
  logic                  m_wen;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [31:0]           m_din;
  logic [31:0]           m_dout;
  logic                  m_ack;

  logic                  busy;

  // Arbiter side.
  modport slave (
    input  i_ren, i_addr, d_ren, d_wen, d_addr, d_din, m_dout, m_ack,
    output i_dout, i_stall, d_dout, d_stall, m_ren, m_wen, m_addr, m_din, busy
  );

  // Core plus memory side.
  modport master (
    output i_ren, i_addr, d_ren, d_wen, d_addr, d_din, m_dout, m_ack,
    input  i_dout, i_stall, d_dout, d_stall, m_ren, m_wen, m_addr, m_din, busy
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory between fetch and data ports, data first, fetch starvation-bounded.
// Rev 1.0
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);
  localparam logic [3:0] STREAK_MAX = 4'd15;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cap_i_addr;
  logic                  cap_d_wr;
  logic [ADDR_WIDTH-1:0] cap_d_addr;
  logic [31:0]           cap_d_din;
  logic                  done_i;
  logic                  done_d;
  logic [3:0]            streak;

  logic                  m_ren;
  logic                  m_wen;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [31:0]           m_din;
  logic [31:0]           i_dout;
  logic [31:0]           d_dout;

  logic d_req;
  logic match_i;
  logic match_d;
  logic hit_i;
  logic hit_d;
  logic pend_i;
  logic pend_d;

  // Write data only takes part in the match for writes.
  always_comb begin
    d_req   = bus.d_ren | bus.d_wen;
    match_i = bus.i_ren && (bus.i_addr == cap_i_addr);
    match_d = d_req && (bus.d_wen == cap_d_wr) && (bus.d_addr == cap_d_addr)
              && (!bus.d_wen || (bus.d_din == cap_d_din));
    hit_i   = done_i & match_i;
    hit_d   = done_d & match_d;
    pend_i  = bus.i_ren & ~hit_i;
    pend_d  = d_req & ~hit_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cap_i_addr <= '0;
      cap_d_wr   <= 1'b0;
      cap_d_addr <= '0;
      cap_d_din  <= '0;
      done_i     <= 1'b0;
      done_d     <= 1'b0;
      streak     <= '0;
      m_ren      <= 1'b0;
      m_wen      <= 1'b0;
      m_addr     <= '0;
      m_din      <= '0;
      i_dout     <= '0;
      d_dout     <= '0;
    end else begin
      if (!match_i) done_i <= 1'b0;
      if (!match_d) done_d <= 1'b0;
      case (state)
        IDLE: begin
          if (!pend_i) streak <= '0;
          if (pend_d && (!pend_i || (streak < LIMIT))) begin
            state      <= BUSY_D;
            cap_d_wr   <= bus.d_wen;
            cap_d_addr <= bus.d_addr;
            cap_d_din  <= bus.d_din;
            m_ren      <= ~bus.d_wen;
            m_wen      <= bus.d_wen;
            m_addr     <= bus.d_addr;
            m_din      <= bus.d_din;
            if (pend_i && (streak != STREAK_MAX)) streak <= streak + 4'd1;
          end else if (pend_i) begin
            state      <= BUSY_I;
            cap_i_addr <= bus.i_addr;
            m_ren      <= 1'b1;
            m_wen      <= 1'b0;
            m_addr     <= bus.i_addr;
            m_din      <= '0;
            streak     <= '0;
          end
        end
        BUSY_I: begin
          if (bus.m_ack) begin
            i_dout <= bus.m_dout;
            done_i <= 1'b1;
            state  <= IDLE;
            m_ren  <= 1'b0;
            m_wen  <= 1'b0;
            m_addr <= '0;
            m_din  <= '0;
          end
        end
        BUSY_D: begin
          if (bus.m_ack) begin
            if (!cap_d_wr) d_dout <= bus.m_dout;
            // A completed write may have overwritten the word fetch is holding.
            if (cap_d_wr) done_i <= 1'b0;
            done_d <= 1'b1;
            state  <= IDLE;
            m_ren  <= 1'b0;
            m_wen  <= 1'b0;
            m_addr <= '0;
            m_din  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.i_stall = pend_i;
  assign bus.d_stall = pend_d;
  assign bus.i_dout  = i_dout;
  assign bus.d_dout  = d_dout;
  assign bus.m_ren   = m_ren;
  assign bus.m_wen   = m_wen;
  assign bus.m_addr  = m_addr;
  assign bus.m_din   = m_din;
  assign bus.busy    = (state != IDLE);

endmodule

`default_nettype wire
